// File: rtl/scope_capture.sv
// -----------------------------------------------------------------------------
// scope_capture
//
// Acquisition and trace-render stage placed directly upstream of the VGA timing
// generator. During the lower vertical blank one triggered record of 640 ADC
// samples is captured into the back bank of a double buffer. A complete record
// swaps the banks. Outside the blank, the display bank is read at the current
// raster column and compared against the raster row to draw the trace over a
// graticule.
//
// Optional feature (macro SCOPE_AUTOTRIG_EN):
//   When defined, a blank that ends with no trigger arms an auto-trigger. The
//   first sample of the next armed period then starts a capture, so a flat or
//   sub-threshold signal still appears on screen.
//   When undefined, capture strictly requires a rising crossing of trig_level.
//
// Parameters:
//   SAMPLE_W     ADC sample width (the row mapping assumes 8)
//   TRACE_COLOR  RRGGBB colour of the trace
//   GRID_COLOR   RRGGBB colour of the graticule
//
// Ports:
//   clk          pixel clock, shared with the VGA timing generator
//   reset        asynchronous, active-low reset
//   adc_data     ADC sample, qualified by adc_valid
//   adc_valid    one-cycle strobe per new sample
//   trig_level   rising-edge trigger threshold (unsigned)
//   hcounter     horizontal raster position
//   vcounter     vertical raster position
//   lower_blank  high while vcounter > 479
//   color_px     pixel colour, 2 clocks after hcounter/vcounter
//   armed        FSM is waiting for a trigger
//   capturing    FSM is filling the back bank
//   frame_done   one-cycle pulse on each bank swap
// -----------------------------------------------------------------------------
module scope_capture #(
   parameter int         SAMPLE_W    = 8,
   parameter logic [5:0] TRACE_COLOR = 6'b001100,
   parameter logic [5:0] GRID_COLOR  = 6'b010101
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [SAMPLE_W-1:0] adc_data,
   input  logic                adc_valid,
   input  logic [SAMPLE_W-1:0] trig_level,
   input  logic [10:0]         hcounter,
   input  logic [9:0]          vcounter,
   input  logic                lower_blank,
   output logic [5:0]          color_px,
   output logic                armed,
   output logic                capturing,
   output logic                frame_done
);

   localparam int         DEPTH     = 640;
   localparam logic [9:0] LAST_ADDR = 10'd639;

   typedef enum logic [1:0] {
      WAIT_BLANK = 2'd0,
      ARMED      = 2'd1,
      CAPTURE    = 2'd2,
      DONE       = 2'd3
   } state_t;

   // ---------------------------------------------------------------------------
   // Capture control state
   // ---------------------------------------------------------------------------
   state_t              state_q, state_d;
   logic [9:0]          wr_addr_q, wr_addr_d;
   logic                disp_bank_q, disp_bank_d;
   logic [SAMPLE_W-1:0] prev_sample_q, prev_sample_d;
   logic                frame_done_q, frame_done_d;
   logic                armed_q, armed_d;
   logic                capturing_q, capturing_d;

`ifdef SCOPE_AUTOTRIG_EN
   logic                auto_pending_q, auto_pending_d;
`endif

   // Buffer write port controls
   logic                wr_en_s;
   logic [9:0]          wr_at_s;
   logic                cross_s;
   logic                trig_hit_s;

   // ---------------------------------------------------------------------------
   // Sample store and render pipeline
   // ---------------------------------------------------------------------------
   logic [SAMPLE_W-1:0] bank0_mem [0:DEPTH-1];
   logic [SAMPLE_W-1:0] bank1_mem [0:DEPTH-1];
   logic [9:0]          rd_addr_s;
   logic [SAMPLE_W-1:0] rd_data_q;
   logic [10:0]         hc_q, hc_d;
   logic [9:0]          vc_q, vc_d;
   logic [9:0]          y_s;
   logic                visible_s;
   logic [5:0]          color_px_q, color_px_d;

   // Rising crossing: previous sample below threshold, current at or above it.
   assign cross_s = adc_valid && (prev_sample_q < trig_level) && (adc_data >= trig_level);

`ifdef SCOPE_AUTOTRIG_EN
   // A pending auto-trigger turns the first strobe seen while armed into a trigger.
   assign trig_hit_s = cross_s || (adc_valid && auto_pending_q);
`else
   assign trig_hit_s = cross_s;
`endif

   // Next-state logic for the capture FSM, the write port and the status outputs.
   always_comb begin
      state_d       = state_q;
      wr_addr_d     = wr_addr_q;
      disp_bank_d   = disp_bank_q;
      wr_en_s       = 1'b0;
      wr_at_s       = wr_addr_q;
      frame_done_d  = 1'b0;
      prev_sample_d = prev_sample_q;
`ifdef SCOPE_AUTOTRIG_EN
      auto_pending_d = auto_pending_q;
`endif

      if (adc_valid) begin
         prev_sample_d = adc_data;
      end else begin
         prev_sample_d = prev_sample_q;
      end

      case (state_q)
         WAIT_BLANK: begin
            if (lower_blank) begin
               state_d = ARMED;
            end else begin
               state_d = WAIT_BLANK;
            end
         end

         ARMED: begin
            // The end of the blank wins over a trigger arriving in that cycle.
            if (!lower_blank) begin
               state_d   = WAIT_BLANK;
               wr_addr_d = 10'd0;
`ifdef SCOPE_AUTOTRIG_EN
               auto_pending_d = 1'b1;
`endif
            end else if (trig_hit_s) begin
               // The trigger sample itself is the first sample of the record.
               wr_en_s   = 1'b1;
               wr_at_s   = 10'd0;
               wr_addr_d = 10'd1;
               state_d   = CAPTURE;
`ifdef SCOPE_AUTOTRIG_EN
               auto_pending_d = 1'b0;
`endif
            end else begin
               state_d = ARMED;
            end
         end

         CAPTURE: begin
            // The final write completes the record even when the blank ends in
            // the same cycle; any earlier end of blank discards the record.
            if (adc_valid && (wr_addr_q == LAST_ADDR)) begin
               wr_en_s      = 1'b1;
               disp_bank_d  = ~disp_bank_q;
               frame_done_d = 1'b1;
               wr_addr_d    = 10'd0;
               if (lower_blank) begin
                  state_d = DONE;
               end else begin
                  state_d = WAIT_BLANK;
               end
            end else if (!lower_blank) begin
               state_d   = WAIT_BLANK;
               wr_addr_d = 10'd0;
            end else if (adc_valid) begin
               wr_en_s   = 1'b1;
               wr_addr_d = wr_addr_q + 10'd1;
               state_d   = CAPTURE;
            end else begin
               state_d = CAPTURE;
            end
         end

         DONE: begin
            // Hold off until the blank ends so only one record is taken per frame.
            if (!lower_blank) begin
               state_d = WAIT_BLANK;
            end else begin
               state_d = DONE;
            end
         end

         default: begin
            state_d   = WAIT_BLANK;
            wr_addr_d = 10'd0;
         end
      endcase

      armed_d     = (state_d == ARMED);
      capturing_d = (state_d == CAPTURE);
   end

   // Capture FSM, bank select, previous sample and status output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= WAIT_BLANK;
         wr_addr_q     <= 10'd0;
         disp_bank_q   <= 1'b0;
         prev_sample_q <= '0;
         frame_done_q  <= 1'b0;
         armed_q       <= 1'b0;
         capturing_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         wr_addr_q     <= wr_addr_d;
         disp_bank_q   <= disp_bank_d;
         prev_sample_q <= prev_sample_d;
         frame_done_q  <= frame_done_d;
         armed_q       <= armed_d;
         capturing_q   <= capturing_d;
      end
   end

`ifdef SCOPE_AUTOTRIG_EN
   // Auto-trigger request flag.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         auto_pending_q <= 1'b0;
      end else begin
         auto_pending_q <= auto_pending_d;
      end
   end
`endif

   // Columns beyond the record are never visible; park the read address at 0.
   assign rd_addr_s = (hcounter[9:0] < 10'd640) ? hcounter[9:0] : 10'd0;

   // Double-buffered sample store: capture writes the back bank, render reads
   // the display bank through an output register (no reset, RAM-friendly).
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         if (disp_bank_q) begin
            bank0_mem[wr_at_s] <= adc_data;
         end else begin
            bank1_mem[wr_at_s] <= adc_data;
         end
      end
      if (disp_bank_q) begin
         rd_data_q <= bank1_mem[rd_addr_s];
      end else begin
         rd_data_q <= bank0_mem[rd_addr_s];
      end
   end

   // Render stage 2: trace row compare, graticule and colour priority.
   always_comb begin
      hc_d       = hcounter;
      vc_d       = vcounter;
      // Row 367 is zero; full scale 255 lands on row 112.
      y_s        = 10'd367 - 10'(rd_data_q);
      visible_s  = (hc_q < 11'd640) && (vc_q < 10'd480);
      color_px_d = 6'd0;
      if (visible_s && (vc_q == y_s)) begin
         color_px_d = TRACE_COLOR;
      end else if (visible_s && ((hc_q[5:0] == 6'd0) || (vc_q == 10'd240))) begin
         color_px_d = GRID_COLOR;
      end else begin
         color_px_d = 6'd0;
      end
   end

   // Render pipeline: raster position aligned with the RAM read, then colour.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hc_q       <= 11'd0;
         vc_q       <= 10'd0;
         color_px_q <= 6'd0;
      end else begin
         hc_q       <= hc_d;
         vc_q       <= vc_d;
         color_px_q <= color_px_d;
      end
   end

   assign color_px   = color_px_q;
   assign armed      = armed_q;
   assign capturing  = capturing_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_scope_capture.sv
// -----------------------------------------------------------------------------
// tb_scope_capture
//
// Randomised scoreboard bench for scope_capture. Each blank is planned as a
// list of (cycle, value) samples; a reference model decides from that list
// whether a record completes and what it contains. Expected frame_done pulses
// and expected pixel colours are queued when stimulus is issued and a monitor
// compares them against the DUT on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_scope_capture;

   localparam logic [5:0] TRACE = 6'b001100;
   localparam logic [5:0] GRID  = 6'b010101;
`ifdef SCOPE_AUTOTRIG_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  adc_data;
   logic        adc_valid;
   logic [7:0]  trig_level;
   logic [10:0] hcounter;
   logic [9:0]  vcounter;
   logic        lower_blank;
   logic [5:0]  color_px;
   logic        armed;
   logic        capturing;
   logic        frame_done;

   scope_capture #(
      .SAMPLE_W    (8),
      .TRACE_COLOR (TRACE),
      .GRID_COLOR  (GRID)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .adc_data    (adc_data),
      .adc_valid   (adc_valid),
      .trig_level  (trig_level),
      .hcounter    (hcounter),
      .vcounter    (vcounter),
      .lower_blank (lower_blank),
      .color_px    (color_px),
      .armed       (armed),
      .capturing   (capturing),
      .frame_done  (frame_done)
   );

   always #20 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      int         due;
      int         hc;
      int         vc;
      logic [5:0] exp;
   } px_t;

   px_t px_q[$];
   int  fd_q[$];
   int  fd_seen = 0;

   // Reference model state
   int  m_prev;
   bit  m_pending;
   bit  m_disp_ok;
   int  m_disp[640];
   int  trig;
   int  s_cyc[$];
   int  s_val[$];

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [5:0] model_px(input int hc, input int vc);
      if (hc < 640 && vc < 480) begin
         if (vc == 367 - m_disp[hc]) return TRACE;
         if ((hc % 64) == 0 || vc == 240) return GRID;
      end
      return 6'd0;
   endfunction

   // Index of the sample that starts the record, or -1 if the blank never triggers.
   function automatic int find_trig(input int L);
      int prev;
      prev = m_prev;
      for (int i = 0; i < s_val.size(); i++) begin
         if (s_cyc[i] >= 1 && s_cyc[i] <= L - 1) begin
            if ((AUTO && m_pending) || (prev < trig && s_val[i] >= trig)) return i;
         end
         prev = s_val[i];
      end
      return -1;
   endfunction

   // mode 0: ramp from 0, 1: random values with random gaps, 2: constant 50
   task automatic build(input int mode, input int L, input int P);
      int c;
      int v;
      s_cyc.delete();
      s_val.delete();
      c = int'($urandom_range(0, 3));
      v = 0;
      while (c <= L) begin
         s_cyc.push_back(c);
         if (mode == 0)      s_val.push_back(v % 256);
         else if (mode == 1) s_val.push_back(int'($urandom_range(0, 255)));
         else                s_val.push_back(50);
         v++;
         if (mode == 1) c += int'($urandom_range(1, P));
         else           c += P;
      end
   endtask

   task automatic run_blank(input string tag, input int L);
      int ti;
      int ok;
      int start;
      int fd0;
      int k;
      ti = find_trig(L);
      ok = (ti >= 0 && ti + 639 < s_val.size()) ? ((s_cyc[ti + 639] <= L) ? 1 : 0) : 0;
      fd0 = fd_seen;
      k = 0;
      start = 0;
      trig_level = 8'(trig);
      for (int c = 0; c <= L + 4; c++) begin
         @(negedge clk);
         if (c == 0) begin
            start = cyc;
            if (ok == 1) fd_q.push_back(start + s_cyc[ti + 639] + 1);
         end
         if (c == 1) check({tag, " armed at blank start"}, int'(armed), 1);
         if (ti >= 0 && c == s_cyc[ti] + 1) check({tag, " capturing after trigger"}, int'(capturing), 1);
         lower_blank = (c < L) ? 1'b1 : 1'b0;
         hcounter    = 11'd0;
         vcounter    = 10'd500;
         if (k < s_cyc.size() && s_cyc[k] == c) begin
            adc_valid = 1'b1;
            adc_data  = 8'(s_val[k]);
            k++;
         end else begin
            adc_valid = 1'b0;
         end
      end
      @(negedge clk);
      adc_valid = 1'b0;
      check({tag, " frame_done count"}, fd_seen - fd0, ok);
      check({tag, " armed after blank"}, int'(armed), 0);
      check({tag, " capturing after blank"}, int'(capturing), 0);
      if (s_val.size() > 0) m_prev = s_val[s_val.size() - 1];
      if (AUTO) m_pending = (ti < 0) ? 1'b1 : 1'b0;
      if (ok == 1) begin
         m_disp_ok = 1'b1;
         for (int i = 0; i < 640; i++) m_disp[i] = s_val[ti + i];
      end
   endtask

   // Drive one raster position (caller is at a falling edge) and queue its colour.
   task automatic drive_px(input int hc, input int vc);
      px_t e;
      lower_blank = 1'b0;
      adc_valid   = 1'b0;
      hcounter    = 11'(hc);
      vcounter    = 10'(vc);
      if (m_disp_ok) begin
         e.due = cyc + 2;
         e.hc  = hc;
         e.vc  = vc;
         e.exp = model_px(hc, vc);
         px_q.push_back(e);
      end
   endtask

   task automatic render(input int n);
      int hc;
      int vc;
      int sel;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         sel = int'($urandom_range(0, 5));
         hc  = int'($urandom_range(0, 639));
         vc  = int'($urandom_range(0, 479));
         case (sel)
            0: vc = 367 - m_disp[hc];
            1: vc = 240;
            2: hc = 64 * int'($urandom_range(0, 9));
            3: begin
               hc = int'($urandom_range(0, 2047));
               vc = int'($urandom_range(0, 1023));
            end
            4: vc = 368 - m_disp[hc];
            default: ;
         endcase
         drive_px(hc, vc);
      end
   endtask

   // Scoreboard monitor: colours due this cycle and every frame_done pulse.
   always @(negedge clk) begin : monitor
      px_t e;
      int  d;
      while (px_q.size() > 0 && px_q[0].due <= cyc) begin
         e = px_q.pop_front();
         n_tests++;
         if (e.due != cyc || color_px !== e.exp) begin
            n_fail++;
            $display("FAIL render hc=%0d vc=%0d: color_px=%b expected %b (due %0d, now %0d)",
                     e.hc, e.vc, color_px, e.exp, e.due, cyc);
         end
      end
      if (frame_done === 1'b1) begin
         fd_seen++;
         n_tests++;
         if (fd_q.size() == 0) begin
            n_fail++;
            $display("FAIL frame_done: pulse at cycle %0d, expected none", cyc);
         end else begin
            d = fd_q.pop_front();
            if (d != cyc) begin
               n_fail++;
               $display("FAIL frame_done timing: pulse at cycle %0d, expected cycle %0d", cyc, d);
            end
         end
      end
   end

   initial begin
      int ti;
      int L;
      reset       = 1'b0;
      adc_data    = 8'd0;
      adc_valid   = 1'b0;
      trig_level  = 8'd128;
      hcounter    = 11'd0;
      vcounter    = 10'd0;
      lower_blank = 1'b0;
      m_prev      = 0;
      m_pending   = 1'b0;
      m_disp_ok   = 1'b0;
      trig        = 128;

      // Reset state
      repeat (3) @(negedge clk);
      check("reset color_px", int'(color_px), 0);
      check("reset armed", int'(armed), 0);
      check("reset capturing", int'(capturing), 0);
      check("reset frame_done", int'(frame_done), 0);
      reset = 1'b1;

      // Reset in the middle of a capture (300 samples written)
      lower_blank = 1'b1;
      for (int k = 0; k <= 427; k++) begin
         @(negedge clk);
         adc_valid = 1'b1;
         adc_data  = 8'(k % 256);
         @(negedge clk);
         adc_valid = 1'b0;
      end
      @(negedge clk);
      check("capturing before mid-capture reset", int'(capturing), 1);
      reset = 1'b0;
      #1;
      check("mid-capture reset color_px", int'(color_px), 0);
      check("mid-capture reset armed", int'(armed), 0);
      check("mid-capture reset capturing", int'(capturing), 0);
      check("mid-capture reset frame_done", int'(frame_done), 0);
      lower_blank = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      check("after reset armed (WAIT_BLANK)", int'(armed), 0);
      check("after reset capturing", int'(capturing), 0);
      m_prev    = 0;
      m_pending = 1'b0;

      // Ramp 0..255 at one strobe per 4 clocks, threshold 128
      trig = 128;
      build(0, 4000, 4);
      run_blank("ramp", 4000);
      @(negedge clk); drive_px(10, 367 - m_disp[10]);
      @(negedge clk); drive_px(10, 368 - m_disp[10]);
      @(negedge clk); drive_px(64, 168);
      @(negedge clk); drive_px(639, 367 - m_disp[639]);
      @(negedge clk); drive_px(0, 367 - m_disp[0]);
      render(500);

      // Random data and threshold
      trig = int'($urandom_range(20, 235));
      build(1, 2000, 3);
      run_blank("random1", 2000);
      render(400);

      // Too slow to finish a record: abort, display keeps the previous record
      trig = 128;
      build(0, 3000, 8);
      run_blank("abort", 3000);
      render(300);

      // Final write lands in the cycle the blank ends
      trig = 128;
      build(0, 4000, 3);
      ti = find_trig(4000);
      L = 4000;
      if (ti >= 0 && ti + 639 < s_cyc.size()) L = s_cyc[ti + 639];
      while (s_cyc.size() > 0 && s_cyc[s_cyc.size() - 1] > L) begin
         void'(s_cyc.pop_back());
         void'(s_val.pop_back());
      end
      run_blank("boundary", L);
      render(300);

      // Constant sub-threshold signal over three frames
      for (int f = 0; f < 3; f++) begin
         trig = 128;
         build(2, 2200, 3);
         run_blank("const", 2200);
         render(300);
      end

      // A couple more random frames
      for (int f = 0; f < 2; f++) begin
         trig = int'($urandom_range(20, 235));
         build(1, 2200, 3);
         run_blank("random2", 2200);
         render(300);
      end

      repeat (4) @(negedge clk);
      check("outstanding frame_done", fd_q.size(), 0);
      check("outstanding pixels", px_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
